// File: rtl/keycode_action_decoder.sv
// keycode_action_decoder
// Turns the USB host's keycode slots into per-action game controls. Each action
// has a runtime-writable keycode binding. The block samples once per video frame.
// For every action it produces:
//   - a held level,
//   - pressed and released edge pulses,
//   - a typematic auto-repeat pulse.
// A frame that reports ErrorRollOver (0x01) in any slot is thrown away, so a
// transient phantom-key condition cannot release or press anything.
module keycode_action_decoder #(
  parameter int NUM_SLOTS    = 4,
  parameter int NUM_ACTIONS  = 8,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 5
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           frame_strobe,
  input  logic [NUM_SLOTS*8-1:0]         keycodes,
  input  logic                           map_we,
  input  logic [$clog2(NUM_ACTIONS)-1:0] map_addr,
  input  logic [7:0]                     map_data,
  output logic [NUM_ACTIONS-1:0]         held,
  output logic [NUM_ACTIONS-1:0]         pressed,
  output logic [NUM_ACTIONS-1:0]         released,
  output logic [NUM_ACTIONS-1:0]         repeat_pulse,
  output logic                           any_held,
  output logic                           rollover
);

  localparam int    CNT_MAX           = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int    CW                = $clog2(CNT_MAX + 1);
  localparam logic [7:0] KEY_ROLLOVER = 8'h01;

  logic [7:0]             map_reg [NUM_ACTIONS];
  logic [NUM_ACTIONS-1:0] raw;
  logic                   rollover_hit;
  logic                   frame_accept;
  logic                   any_held_reg;
  logic                   rollover_reg;

  // Detect ErrorRollOver in any slot of the current report.
  always_comb begin
    rollover_hit = 1'b0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (keycodes[8*k +: 8] == KEY_ROLLOVER) rollover_hit = 1'b1;
    end
  end

  assign frame_accept = frame_strobe & ~rollover_hit;

  // Action map. Strobe logic reads the pre-write contents in a collision cycle,
  // because the write lands at the same edge that consumes the strobe.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_ACTIONS; i++) map_reg[i] <= 8'h00;
    end else if (map_we && (32'(map_addr) < NUM_ACTIONS)) begin
      map_reg[map_addr] <= map_data;
    end
  end

  // any_held follows the held vector. A discarded frame keeps it unchanged.
  // rollover stays set until the next accepted strobe clears it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      any_held_reg <= 1'b0;
      rollover_reg <= 1'b0;
    end else if (frame_strobe) begin
      if (rollover_hit) begin
        rollover_reg <= 1'b1;
      end else begin
        rollover_reg <= 1'b0;
        any_held_reg <= |raw;
      end
    end
  end

  assign any_held = any_held_reg;
  assign rollover = rollover_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ACTIONS; gi++) begin : g_action
      logic          raw_hit;
      logic          held_reg, held_next;
      logic          pressed_reg, pressed_next;
      logic          released_reg, released_next;
      logic          repeat_reg, repeat_next;
      logic [CW-1:0] cnt_reg, cnt_next;

      // An action is raw-active when any slot carries its bound code.
      // Code 0x00 means unbound, and empty slots never match it.
      always_comb begin
        raw_hit = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
          if ((keycodes[8*k +: 8] == map_reg[gi]) && (map_reg[gi] != 8'h00)) raw_hit = 1'b1;
        end
      end

      assign raw[gi] = raw_hit;

      // Compute the next held level, the edge pulses and the repeat schedule.
      // Pulses are masked by their own current value, so none of them can stay
      // high on two consecutive cycles, even with back-to-back strobes.
      always_comb begin
        held_next     = held_reg;
        cnt_next      = cnt_reg;
        pressed_next  = 1'b0;
        released_next = 1'b0;
        repeat_next   = 1'b0;
        if (frame_accept) begin
          held_next     = raw_hit;
          pressed_next  = raw_hit & ~held_reg;
          released_next = ~raw_hit & held_reg;
          if (raw_hit && !held_reg) begin
            cnt_next    = CW'(REPEAT_DELAY);
            repeat_next = 1'b1;
          end else if (raw_hit) begin
            if (cnt_reg > CW'(1)) begin
              cnt_next = cnt_reg - CW'(1);
            end else if (cnt_reg == CW'(1)) begin
              cnt_next    = CW'(REPEAT_RATE);
              repeat_next = 1'b1;
            end
          end else begin
            cnt_next = '0;
          end
        end
        pressed_next  = pressed_next  & ~pressed_reg;
        released_next = released_next & ~released_reg;
        repeat_next   = repeat_next   & ~repeat_reg;
      end

      // Register the per-action state and pulses.
      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          held_reg     <= 1'b0;
          pressed_reg  <= 1'b0;
          released_reg <= 1'b0;
          repeat_reg   <= 1'b0;
          cnt_reg      <= '0;
        end else begin
          held_reg     <= held_next;
          pressed_reg  <= pressed_next;
          released_reg <= released_next;
          repeat_reg   <= repeat_next;
          cnt_reg      <= cnt_next;
        end
      end

      assign held[gi]         = held_reg;
      assign pressed[gi]      = pressed_reg;
      assign released[gi]     = released_reg;
      assign repeat_pulse[gi] = repeat_reg;
    end
  endgenerate

endmodule

// File: tb/tb_keycode_action_decoder.sv
// Testbench for keycode_action_decoder (default parameters)
module tb_keycode_action_decoder;

  logic        Clk;
  logic        Reset_n;
  logic        frame_strobe;
  logic [31:0] keycodes;
  logic        map_we;
  logic [2:0]  map_addr;
  logic [7:0]  map_data;
  logic [7:0]  held, pressed, released, repeat_pulse;
  logic        any_held, rollover;

  int n_cmp = 0;
  int n_bad = 0;

  keycode_action_decoder #(
    .NUM_SLOTS(4), .NUM_ACTIONS(8), .REPEAT_DELAY(20), .REPEAT_RATE(5)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_strobe(frame_strobe), .keycodes(keycodes),
    .map_we(map_we), .map_addr(map_addr), .map_data(map_data),
    .held(held), .pressed(pressed), .released(released), .repeat_pulse(repeat_pulse),
    .any_held(any_held), .rollover(rollover)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  addr;
    logic [7:0]  data;
    logic [31:0] keys;
    logic        strobe;
    logic [7:0]  e_held, e_pressed, e_released, e_repeat;
    logic        e_any, e_roll;
  } vec_t;

  vec_t vecs [17];

  // One comparison of a packed output snapshot against its expected value.
  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic logic [33:0] snap();
    return {held, pressed, released, repeat_pulse, any_held, rollover};
  endfunction

  // Apply one clock with the given strobe, then sample 1 ns after the edge.
  task automatic tick(input logic s);
    frame_strobe = s;
    @(posedge Clk);
    #1;
    frame_strobe = 1'b0;
    map_we       = 1'b0;
  endtask

  task automatic write_map(input logic [2:0] a, input logic [7:0] d);
    map_we   = 1'b1;
    map_addr = a;
    map_data = d;
    tick(1'b0);
  endtask

  function automatic vec_t mk(input string n, input logic we, input logic [2:0] a, input logic [7:0] d,
                              input logic [31:0] k, input logic s, input logic [7:0] h, input logic [7:0] p,
                              input logic [7:0] r, input logic [7:0] rp, input logic an, input logic ro);
    vec_t v;
    v.name = n; v.we = we; v.addr = a; v.data = d; v.keys = k; v.strobe = s;
    v.e_held = h; v.e_pressed = p; v.e_released = r; v.e_repeat = rp; v.e_any = an; v.e_roll = ro;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0; frame_strobe = 1'b0; keycodes = '0;
    map_we = 1'b0; map_addr = '0; map_data = '0;

    // Press, hold without strobe, rollover discard, then release.
    vecs[0]  = mk("t1_press",      0, 0, 8'h00, 32'h001A0000, 1, 8'h01, 8'h01, 8'h00, 8'h01, 1, 0);
    vecs[1]  = mk("t1_pulse_off",  0, 0, 8'h00, 32'h001A0000, 0, 8'h01, 8'h00, 8'h00, 8'h00, 1, 0);
    vecs[2]  = mk("t3_rollover",   0, 0, 8'h00, 32'h001A0001, 1, 8'h01, 8'h00, 8'h00, 8'h00, 1, 1);
    vecs[3]  = mk("t3_release",    0, 0, 8'h00, 32'h00000000, 1, 8'h00, 8'h00, 8'h01, 8'h00, 0, 0);
    vecs[4]  = mk("t3_idle",       0, 0, 8'h00, 32'h00000000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    // Two actions share a keycode, and duplicate slots count once.
    vecs[5]  = mk("t4_map3",       1, 3, 8'h2C, 32'h00000000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    vecs[6]  = mk("t4_map5",       1, 5, 8'h2C, 32'h00000000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    vecs[7]  = mk("t4_shared",     0, 0, 8'h00, 32'h00002C00, 1, 8'h28, 8'h28, 8'h00, 8'h28, 1, 0);
    vecs[8]  = mk("t4_dup_slots",  0, 0, 8'h00, 32'h2C2C2C2C, 1, 8'h28, 8'h00, 8'h00, 8'h00, 1, 0);
    vecs[9]  = mk("t4_release",    0, 0, 8'h00, 32'h00000000, 1, 8'h00, 8'h00, 8'h28, 8'h00, 0, 0);
    // A map write that collides with a strobe uses the old entry.
    vecs[10] = mk("t5_press",      0, 0, 8'h00, 32'h0000001A, 1, 8'h01, 8'h01, 8'h00, 8'h01, 1, 0);
    vecs[11] = mk("t5_we_strobe",  1, 0, 8'h04, 32'h0000001A, 1, 8'h01, 8'h00, 8'h00, 8'h00, 1, 0);
    vecs[12] = mk("t5_remap_rel",  0, 0, 8'h00, 32'h0000001A, 1, 8'h00, 8'h00, 8'h01, 8'h00, 0, 0);
    vecs[13] = mk("t5_restore",    1, 0, 8'h1A, 32'h00000000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    // rollover stays set across non-strobe cycles and clears on an accepted strobe.
    vecs[14] = mk("ro_set",        0, 0, 8'h00, 32'h00000100, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1);
    vecs[15] = mk("ro_sticky",     0, 0, 8'h00, 32'h00000000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1);
    vecs[16] = mk("ro_clear",      0, 0, 8'h00, 32'h00000000, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);

    #12;
    check("reset_state", snap(), 34'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    write_map(3'd0, 8'h1A);

    for (int i = 0; i < 17; i++) begin
      keycodes = vecs[i].keys;
      map_we   = vecs[i].we;
      map_addr = vecs[i].addr;
      map_data = vecs[i].data;
      tick(vecs[i].strobe);
      check(vecs[i].name, snap(), {vecs[i].e_held, vecs[i].e_pressed, vecs[i].e_released,
                                   vecs[i].e_repeat, vecs[i].e_any, vecs[i].e_roll});
    end

    // Auto-repeat: hold 0x1A for 30 back-to-back strobes.
    // Repeats are expected on strobes 1, 21 and 26 only.
    keycodes = 32'h0000001A;
    for (int n = 1; n <= 30; n++) begin
      logic [1:0] exp_pr;
      exp_pr = {(n == 1 || n == 21 || n == 26), (n == 1)};
      tick(1'b1);
      check($sformatf("t2_strobe%0d", n), {32'h0, repeat_pulse[0], pressed[0]}, {32'h0, exp_pr});
    end
    tick(1'b0);
    check("t2_after", snap(), {8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0});

    // Async reset mid-repeat with all actions held.
    for (int a = 0; a < 8; a++) write_map(3'(a), 8'h2C);
    keycodes = 32'h0000002C;
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    check("t6_all_held", {held, 26'h0, any_held}, {8'hFF, 26'h0, 1'b1});
    Reset_n = 1'b0;
    #1;
    check("t6_async_clear", snap(), 34'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    tick(1'b1);
    check("t6_map_cleared", snap(), 34'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
